irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
Parametrised successor to the 4-input combinational priority encoder. Latches NUM_IRQ interrupt sources into a pending register, applies a software mask, and presents the highest-priority request (lowest index wins) to the CPU. Requests are held stable until the CPU acknowledges them, and a new request is blocked until end-of-interrupt. Sits between peripheral interrupt lines and the CPU core's interrupt input.

Parameters:
NUM_IRQ, 8, number of interrupt sources; legal range 2..32.
ID_W, $clog2(NUM_IRQ), width of the vector id; derived, not overridden.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
interrupts  in  NUM_IRQ  raw source lines; bit 0 has highest priority
mask_we  in  1  write strobe for the mask register
mask_in  in  NUM_IRQ  new mask value; 1 = source masked
ack  in  1  CPU accepts the current request
eoi  in  1  CPU finished servicing; re-arms the controller
y  out  ID_W  id of the presented or in-service source
IRQ  out  1  request to the CPU
in_service  out  1  high while in SERVICE state
pending_out  out  NUM_IRQ  pending register; read-only visibility

Behaviour:
- Reset: pending=0, mask=0 (all enabled), state=IDLE, y=0, IRQ=0, in_service=0. Reset overrides every other input in the same cycle.
- Pending capture: pending[i] is set in any cycle where the capture condition holds (level mode: interrupts[i]==1). Bits stay set until cleared by ack.
- Same-cycle set and clear of the same bit: set wins.
- Mask: on mask_we, mask <= mask_in at the next edge. Masked sources still latch into pending but are not eligible for selection.
- Eligible vector: pending & ~mask. Selection picks the lowest set index.
- FSM:
  - IDLE: IRQ=0. If eligible != 0, register y <= selected id and go to REQ.
  - REQ: IRQ=1 and y held constant. Changes to mask or pending do not retract or change the request. On ack: clear pending[y], go to SERVICE.
  - SERVICE: IRQ=0, in_service=1, y holds the serviced id. On eoi: go to IDLE.
- Ignored inputs: ack outside REQ; eoi outside SERVICE.
- Latency: a source rising in cycle N is pending at N+1. IRQ is high at N+2 when the FSM starts in IDLE.
- Back-to-back requests: after eoi, the next eligible source is presented two edges later (IDLE re-evaluates, then REQ).
- Reset mid-operation: returns to IDLE; any outstanding request or service is dropped.
- No eligible source: y stays at its last value; IRQ stays 0.

Optional Feature:
IRQ_EDGE_DETECT_EN:
- Defined: a registered copy of interrupts is kept (reset 0). pending[i] sets only on a 0->1 transition. A source held high latches once and does not re-pend after ack until it falls and rises again.
- Undefined: level capture. A source still high after ack re-pends on the next edge.

Decomposition:
- Package irq_pkg holds:
  - IRQ state enum: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2.
  - MAX_IRQ=32.
  - Function clog2_min1 for ID_W.
- One sub-module: prio_enc_n. It is a combinational, parametrised NUM_IRQ-to-ID_W lowest-index encoder with a valid output, instantiated on the eligible vector.

Test Plan:
(All with NUM_IRQ=8, level mode unless stated.)
1. Reset then idle: interrupts=0 for 5 cycles -> IRQ=0, y=0, pending_out=0, in_service=0.
2. Priority: interrupts=8'b1010_0100 for 1 cycle -> IRQ=1 two edges later with y=2. After ack, pending_out=8'b1010_0000. After eoi, next request has y=5, then y=7.
3. Mask: mask_in=8'b0000_0100 with mask_we, then interrupts=8'b0000_0110 -> y=1. The masked bit 2 stays in pending_out. Clearing the mask after the y=1 eoi -> y=2.
4. Hold during REQ: in REQ with y=3, assert interrupts[0] -> y stays 3 and IRQ stays 1 until ack. After eoi -> y=0.
5. Edge mode (IRQ_EDGE_DETECT_EN): hold interrupts[4]=1 through ack+eoi -> no second request. Drop it, raise it again -> new request with y=4.
6. Reset mid-operation: rst in SERVICE and in REQ -> next cycle IRQ=0, in_service=0, pending_out=0. Spurious ack/eoi in IDLE -> no state change.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state encoding,
// the source-count ceiling and the id-width function.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   localparam int MAX_IRQ = 32;

   // Width of an index into n sources, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational lowest-index-wins priority encoder with a valid flag;
// the N-input successor of the original 4-input encoder.
module prio_enc_n #(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = 3
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic [ID_W-1:0]    id,
   output logic               valid
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no latch is inferred.
      id    = '0;
      valid = 1'b0;
      // Walk from the top down so the lowest set index is written last and wins.
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            id    = ID_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Masked, latched interrupt controller presenting one request at a time to the CPU.
// Define IRQ_EDGE_DETECT_EN for rising-edge capture; level capture otherwise.
module irq_controller
   import irq_pkg::*;
#(
   parameter  int NUM_IRQ = 8,
   localparam int ID_W    = clog2_min1(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] interrupts,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_in,
   input  logic               ack,
   input  logic               eoi,
   output logic [ID_W-1:0]    y,
   output logic               IRQ,
   output logic               in_service,
   output logic [NUM_IRQ-1:0] pending_out
);

   irq_state_e         state_q, state_d;
   logic [NUM_IRQ-1:0] pending_q, mask_q, capture, clear, eligible;
   logic [ID_W-1:0]    y_q, sel_id;
   logic               sel_valid;

`ifdef IRQ_EDGE_DETECT_EN
   logic [NUM_IRQ-1:0] irq_q;

   always_ff @(posedge clk) begin
      if (rst) irq_q <= '0;
      else     irq_q <= interrupts;
   end

   assign capture = interrupts & ~irq_q;
`else
   assign capture = interrupts;
`endif

   assign eligible = pending_q & ~mask_q;

   prio_enc_n #(
      .NUM_IRQ (NUM_IRQ),
      .ID_W    (ID_W)
   ) u_prio_enc (
      .req   (eligible),
      .id    (sel_id),
      .valid (sel_valid)
   );

   always_comb begin
      clear = '0;
      if (state_q == REQ && ack) clear[y_q] = 1'b1;
   end

   // Capture is OR-ed in after the clear so a same-cycle set wins.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (rst) begin
         pending_q <= '0;
         mask_q    <= '0;
         y_q       <= '0;
      end else begin
         pending_q <= (pending_q & ~clear) | capture;
         if (mask_we) mask_q <= mask_in;
         if (state_q == IDLE && sel_valid) y_q <= sel_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (sel_valid) state_d = REQ;
         REQ:     if (ack)       state_d = SERVICE;
         SERVICE: if (eoi)       state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      IRQ        = (state_q == REQ);
      in_service = (state_q == SERVICE);
   end

   assign y           = y_q;
   assign pending_out = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed and random checks of irq_controller (NUM_IRQ=8) against a
// behavioural model built from pending bits, a mask and request/service flags.
module tb_irq_controller;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst, mask_we, ack, eoi;
   logic [N-1:0] interrupts, mask_in, pending_out;
   logic [2:0]   y;
   logic         irq, in_service;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [N-1:0] m_pend, m_mask, m_prev;
   bit           m_req, m_srv;
   int           m_y;

   irq_controller #(.NUM_IRQ(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .interrupts  (interrupts),
      .mask_we     (mask_we),
      .mask_in     (mask_in),
      .ack         (ack),
      .eoi         (eoi),
      .y           (y),
      .IRQ         (irq),
      .in_service  (in_service),
      .pending_out (pending_out)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_edge();
      logic [N-1:0] cap, nxt, elig;
      if (rst) begin
         m_pend = '0; m_mask = '0; m_prev = '0;
         m_req  = 0;  m_srv  = 0;  m_y    = 0;
         return;
      end
`ifdef IRQ_EDGE_DETECT_EN
      cap = interrupts & ~m_prev;
`else
      cap = interrupts;
`endif
      elig = m_pend & ~m_mask;
      nxt  = m_pend;
      if (m_req && ack) nxt[m_y] = 1'b0;
      nxt = nxt | cap;
      if (!m_req && !m_srv) begin
         if (elig != 0) begin
            m_y   = lowest(elig);
            m_req = 1;
         end
      end else if (m_req) begin
         if (ack) begin m_req = 0; m_srv = 1; end
      end else if (eoi) begin
         m_srv = 0;
      end
      if (mask_we) m_mask = mask_in;
      m_pend = nxt;
      m_prev = interrupts;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check({tag, ".irq"},     32'(irq),         32'(m_req));
      check({tag, ".svc"},     32'(in_service),  32'(m_srv));
      check({tag, ".y"},       32'(y),           32'(m_y));
      check({tag, ".pending"}, 32'(pending_out), 32'(m_pend));
   endtask

   task automatic do_ack(input string tag);
      ack = 1'b1; step(tag); ack = 1'b0;
   endtask

   task automatic do_eoi(input string tag);
      eoi = 1'b1; step(tag); eoi = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mask_we = 1'b0; ack = 1'b0; eoi = 1'b0;
      interrupts = '0; mask_in = '0;
      m_pend = '0; m_mask = '0; m_prev = '0; m_req = 0; m_srv = 0; m_y = 0;
      step("reset"); step("reset");
      rst = 1'b0;

      // 1: idle after reset
      for (int i = 0; i < 5; i++) step("idle");
      check("idle_irq", 32'(irq), 32'd0);
      check("idle_y", 32'(y), 32'd0);
      check("idle_pending", 32'(pending_out), 32'd0);
      check("idle_svc", 32'(in_service), 32'd0);

      // 2: priority ordering
      interrupts = 8'b1010_0100; step("prio_cap");
      interrupts = '0;           step("prio_req");
      check("prio_irq", 32'(irq), 32'd1);
      check("prio_y2", 32'(y), 32'd2);
      do_ack("prio_ack");
      check("prio_pend_after_ack", 32'(pending_out), 32'b1010_0000);
      do_eoi("prio_eoi"); step("prio_next");
      check("prio_y5", 32'(y), 32'd5);
      do_ack("prio_ack5"); do_eoi("prio_eoi5"); step("prio_next7");
      check("prio_y7", 32'(y), 32'd7);
      do_ack("prio_ack7"); do_eoi("prio_eoi7");

      // 3: mask
      mask_in = 8'b0000_0100; mask_we = 1'b1; step("mask_wr"); mask_we = 1'b0;
      interrupts = 8'b0000_0110; step("mask_cap");
      interrupts = '0;           step("mask_req");
      check("mask_y1", 32'(y), 32'd1);
      do_ack("mask_ack");
      check("mask_pend_bit2", 32'(pending_out), 32'b0000_0100);
      do_eoi("mask_eoi");
      check("mask_blocked", 32'(irq), 32'd0);
      mask_in = '0; mask_we = 1'b1; step("mask_clr"); mask_we = 1'b0;
      step("mask_req2");
      check("mask_y2", 32'(y), 32'd2);
      check("mask_irq2", 32'(irq), 32'd1);
      do_ack("mask_ack2"); do_eoi("mask_eoi2");

      // 4: request held stable while a higher priority arrives
      interrupts = 8'b0000_1000; step("hold_cap");
      interrupts = '0;           step("hold_req");
      check("hold_y3", 32'(y), 32'd3);
      interrupts = 8'b0000_0001; step("hold_hi");
      interrupts = '0;           step("hold_wait");
      check("hold_y_stays", 32'(y), 32'd3);
      check("hold_irq_stays", 32'(irq), 32'd1);
      do_ack("hold_ack"); do_eoi("hold_eoi"); step("hold_next");
      check("hold_y0", 32'(y), 32'd0);
      do_ack("hold_ack0"); do_eoi("hold_eoi0");

      // 5: held source, edge vs level capture
      interrupts = 8'b0001_0000; step("held_cap"); step("held_req");
      check("held_y4", 32'(y), 32'd4);
      do_ack("held_ack");
`ifdef IRQ_EDGE_DETECT_EN
      check("edge_no_repend", 32'(pending_out), 32'd0);
      do_eoi("edge_eoi"); step("edge_idle"); step("edge_idle");
      check("edge_no_second", 32'(irq), 32'd0);
      interrupts = '0;           step("edge_fall");
      interrupts = 8'b0001_0000; step("edge_rise"); step("edge_req");
      check("edge_y4", 32'(y), 32'd4);
      check("edge_irq", 32'(irq), 32'd1);
      interrupts = '0;
      do_ack("edge_ack"); do_eoi("edge_eoi2");
`else
      check("level_repend", 32'(pending_out), 32'b0001_0000);
      interrupts = '0;
      do_eoi("level_eoi"); step("level_req");
      check("level_y4", 32'(y), 32'd4);
      do_ack("level_ack"); do_eoi("level_eoi2");
`endif

      // 6: reset mid-operation, spurious ack/eoi
      interrupts = 8'b0010_0001; step("rs_cap");
      interrupts = '0;           step("rs_req");
      do_ack("rs_ack");
      check("rs_in_svc", 32'(in_service), 32'd1);
      rst = 1'b1; step("rs_svc_rst"); rst = 1'b0;
      check("rs_svc_irq", 32'(irq), 32'd0);
      check("rs_svc_svc", 32'(in_service), 32'd0);
      check("rs_svc_pend", 32'(pending_out), 32'd0);
      interrupts = 8'b0000_0010; step("rs_cap2");
      interrupts = '0;           step("rs_req2");
      check("rs_req_irq_pre", 32'(irq), 32'd1);
      rst = 1'b1; step("rs_req_rst"); rst = 1'b0;
      check("rs_req_irq", 32'(irq), 32'd0);
      check("rs_req_pend", 32'(pending_out), 32'd0);
      ack = 1'b1; eoi = 1'b1; step("spurious"); ack = 1'b0; eoi = 1'b0;
      check("spurious_irq", 32'(irq), 32'd0);
      check("spurious_svc", 32'(in_service), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         interrupts = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         ack        = ($urandom_range(0, 2) == 0);
         eoi        = ($urandom_range(0, 2) == 0);
         mask_we    = ($urandom_range(0, 7) == 0);
         mask_in    = N'($urandom);
         rst        = ($urandom_range(0, 79) == 0);
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
